// File: rtl/game_sched.sv
// game_sched -- control core for a small arcade-style game.
//
// Sequences the game phases (IDLE/PLAY/OVER/PAUSE), produces the frame tick
// for the datapath, keeps a 4-digit BCD score with saturation, the best score
// since reset, and a difficulty level that rises every LEVEL_STEP points.
//
// Ports:
//   clk      in   system clock, rising edge
//   clr_n    in   asynchronous active-low reset
//   start    in   start button (debounced level)
//   pause    in   pause/resume toggle button (debounced level)
//   ret      in   return-to-menu button (debounced level)
//   plusone  in   point request, one point per rising edge
//   hit      in   collision indication, level
//   tick     out  one-cycle frame-advance pulse (PLAY only)
//   state    out  0 IDLE, 1 PLAY, 2 OVER, 3 PAUSE
//   clr      out  datapath reinitialise, high while in IDLE
//   score    out  current score, 4 BCD digits
//   best     out  best score since reset, 4 BCD digits
//   mode     out  difficulty level 0..7
module game_sched #(
  parameter int TICK_DIV   = 1000000,
  parameter int LEVEL_STEP = 10
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        start,
  input  logic        pause,
  input  logic        ret,
  input  logic        plusone,
  input  logic        hit,
  output logic        tick,
  output logic [1:0]  state,
  output logic        clr,
  output logic [15:0] score,
  output logic [15:0] best,
  output logic [2:0]  mode
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [6:0]       STEP_LAST = 7'(LEVEL_STEP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_OVER  = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t           r_state, w_state_nx;
  logic             r_arm;
  logic [1:0]       r_f_start, r_f_pause, r_f_ret, r_f_plus;
  logic             r_tick, r_clr;
  logic [DIV_W-1:0] r_div;
  logic [15:0]      r_score, r_best;
  logic [6:0]       r_step;
  logic [2:0]       r_mode;
  logic             w_ev_start, w_ev_pause, w_ev_ret, w_ev_plus, w_pt;
  logic [15:0]      w_score_inc;

  // BCD +1 with ripple digit carry; 9999 is a hard ceiling.
  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = (v != 16'h9999);
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] mode_inc_sat(input logic [2:0] m);
    return (m == 3'd7) ? m : m + 3'd1;
  endfunction

  // Input edge filters. On the first edge after reset the filters are
  // loaded with the current level in both bits, so a button already held
  // when reset releases never looks like a fresh press.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_arm     <= 1'b0;
      r_f_start <= 2'b00;
      r_f_pause <= 2'b00;
      r_f_ret   <= 2'b00;
      r_f_plus  <= 2'b00;
    end else begin
      r_arm <= 1'b1;
      if (r_arm) begin
        r_f_start <= {r_f_start[0], start};
        r_f_pause <= {r_f_pause[0], pause};
        r_f_ret   <= {r_f_ret[0],   ret};
        r_f_plus  <= {r_f_plus[0],  plusone};
      end else begin
        r_f_start <= {2{start}};
        r_f_pause <= {2{pause}};
        r_f_ret   <= {2{ret}};
        r_f_plus  <= {2{plusone}};
      end
    end
  end

  assign w_ev_start = (r_f_start == 2'b01);
  assign w_ev_pause = (r_f_pause == 2'b01);
  assign w_ev_ret   = (r_f_ret   == 2'b01);
  assign w_ev_plus  = (r_f_plus  == 2'b01);

  assign w_pt        = w_ev_plus && (r_state == S_PLAY);
  assign w_score_inc = w_pt ? bcd_inc_sat(r_score) : r_score;

  // Phase sequencing; hit outranks pause in PLAY, ret outranks pause in PAUSE.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (w_ev_start) w_state_nx = S_PLAY;
      S_PLAY:  begin
        if (hit)             w_state_nx = S_OVER;
        else if (w_ev_pause) w_state_nx = S_PAUSE;
      end
      S_OVER:  if (w_ev_ret) w_state_nx = S_IDLE;
      S_PAUSE: begin
        if (w_ev_ret)        w_state_nx = S_IDLE;
        else if (w_ev_pause) w_state_nx = S_PLAY;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Registered outputs, all decided from the phase being entered so that
  // clr/tick/score line up with the state they belong to.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_clr   <= 1'b1;
      r_tick  <= 1'b0;
      r_div   <= '0;
      r_score <= '0;
      r_best  <= '0;
      r_step  <= '0;
      r_mode  <= '0;
    end else begin
      r_clr  <= (w_state_nx == S_IDLE);
      r_tick <= 1'b0;
      // Divider advances only across PLAY->PLAY edges; pausing freezes it
      // so a resumed period is never shortened.
      if (r_state == S_PLAY && w_state_nx == S_PLAY) begin
        if (r_div == DIV_LAST) begin
          r_div  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end else if (w_state_nx == S_IDLE || w_state_nx == S_OVER) begin
        r_div <= '0;
      end

      if (w_state_nx == S_IDLE) begin
        r_score <= '0;
        r_step  <= '0;
        r_mode  <= '0;
      end else if (w_pt) begin
        r_score <= w_score_inc;
        if (r_step == STEP_LAST) begin
          r_step <= '0;
          r_mode <= mode_inc_sat(r_mode);
        end else begin
          r_step <= r_step + 7'd1;
        end
      end

      // A point arriving with the fatal hit still counts toward best.
      if (r_state == S_PLAY && w_state_nx == S_OVER && w_score_inc > r_best)
        r_best <= w_score_inc;
    end
  end

  assign state = r_state;
  assign tick  = r_tick;
  assign clr   = r_clr;
  assign score = r_score;
  assign best  = r_best;
  assign mode  = r_mode;

endmodule

// File: tb/tb_game_sched.sv
// tb_game_sched -- directed bench for game_sched with an integer-level
// reference model compared on every falling edge, plus literal spot checks.
module tb_game_sched;
  localparam int TD = 4;
  localparam int LS = 10;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start = 1'b0, pause = 1'b0, ret = 1'b0, plusone = 1'b0, hit = 1'b0;
  logic        tick, clr;
  logic [1:0]  state;
  logic [15:0] score, best;
  logic [2:0]  mode;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  game_sched #(.TICK_DIV(TD), .LEVEL_STEP(LS)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .pause(pause), .ret(ret),
    .plusone(plusone), .hit(hit), .tick(tick), .state(state), .clr(clr),
    .score(score), .best(best), .mode(mode)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases, score as a decimal integer, points since game
  // start, and a count of continuous-play edges for the tick.
  int m_state = 0, m_score = 0, m_best = 0, m_points = 0, m_run = 0, m_edges = 0;
  bit m_tick = 1'b0;
  bit ps1, ps2, pp1, pp2, pr1, pr2, pq1, pq2;
  bit es, ep, er, eq;
  int nxt;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_state = 0; m_score = 0; m_best = 0; m_points = 0; m_run = 0;
      m_edges = 0; m_tick = 1'b0;
      ps1 = 0; ps2 = 0; pp1 = 0; pp2 = 0; pr1 = 0; pr2 = 0; pq1 = 0; pq2 = 0;
    end else begin
      m_edges++;
      // A press counts when the previous sample was high, the one before low,
      // and both were taken after reset released.
      es = (m_edges >= 3) && ps1 && !ps2;
      ep = (m_edges >= 3) && pp1 && !pp2;
      er = (m_edges >= 3) && pr1 && !pr2;
      eq = (m_edges >= 3) && pq1 && !pq2;
      ps2 = ps1; ps1 = start;
      pp2 = pp1; pp1 = pause;
      pr2 = pr1; pr1 = ret;
      pq2 = pq1; pq1 = plusone;
      nxt = m_state;
      case (m_state)
        0: if (es) nxt = 1;
        1: if (hit) nxt = 2; else if (ep) nxt = 3;
        2: if (er) nxt = 0;
        default: if (er) nxt = 0; else if (ep) nxt = 1;
      endcase
      if (m_state == 1 && eq) begin
        m_points++;
        if (m_score < 9999) m_score++;
      end
      if (m_state == 1 && nxt == 1) begin
        m_run++;
        m_tick = ((m_run % TD) == 0);
      end else begin
        m_tick = 1'b0;
      end
      if (nxt == 0 || nxt == 2) m_run = 0;
      if (m_state == 1 && nxt == 2 && m_score > m_best) m_best = m_score;
      if (nxt == 0) begin m_score = 0; m_points = 0; end
      m_state = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_state", state, m_state);
      check("model_clr",   clr,   m_state == 0);
      check("model_tick",  tick,  m_tick);
      check("model_score", score, to_bcd(m_score));
      check("model_best",  best,  to_bcd(m_best));
      check("model_mode",  mode,  (m_points / LS > 7) ? 7 : m_points / LS);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // b: 0 start, 1 pause, 2 ret, 3 plusone. High for one cycle, low for one.
  task automatic pulse(input int b);
    case (b)
      0: start = 1'b1;
      1: pause = 1'b1;
      2: ret = 1'b1;
      default: plusone = 1'b1;
    endcase
    @(negedge clk);
    start = 1'b0; pause = 1'b0; ret = 1'b0; plusone = 1'b0;
    @(negedge clk);
  endtask

  task automatic points(input int n);
    repeat (n) pulse(3);
  endtask

  task automatic do_hit();
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    @(negedge clk);
  endtask

  task automatic count_ticks(input int n, output int tk);
    tk = 0;
    repeat (n) begin
      @(negedge clk);
      if (tick === 1'b1) tk++;
    end
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL timeout: simulation budget exhausted");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int tk;
    clr_n = 1'b0;
    cyc(3);
    chk_en = 1'b1;
    check("rst_state", state, 0);
    check("rst_clr",   clr,   1);
    check("rst_tick",  tick,  0);
    check("rst_score", score, 16'h0000);
    check("rst_best",  best,  16'h0000);
    check("rst_mode",  mode,  0);
    clr_n = 1'b1;
    cyc(2);

    pulse(0);
    check("start_play", state, 1);
    count_ticks(8, tk);
    check("ticks_in_play", tk, 2);
    pulse(1);
    check("pause_state", state, 3);
    count_ticks(6, tk);
    check("ticks_in_pause", tk, 0);
    pulse(1);
    check("resume_state", state, 1);
    cyc(9);

    points(12);
    check("score12", score, 16'h0012);
    do_hit();
    check("over_state", state, 2);
    check("best12", best, 16'h0012);
    pulse(2);
    check("ret_state", state, 0);
    check("ret_clr", clr, 1);
    check("ret_score", score, 16'h0000);
    check("ret_best", best, 16'h0012);
    pulse(0);
    points(5);
    do_hit();
    check("game2_score", score, 16'h0005);
    check("game2_best", best, 16'h0012);
    pulse(2);

    @(negedge clk);
    #2 clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    cyc(2);
    pulse(0);
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    @(negedge clk);
    check("hit_beats_pause", state, 2);
    pulse(2);
    pulse(0);
    points(7);
    plusone = 1'b1;
    @(negedge clk);
    plusone = 1'b0;
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    @(negedge clk);
    check("hit_pt_state", state, 2);
    check("hit_pt_score", score, 16'h0008);
    check("hit_pt_best", best, 16'h0008);

    pulse(2);
    pulse(0);
    points(25);
    check("score25", score, 16'h0025);
    check("mode25", mode, 2);
    points(55);
    check("score80", score, 16'h0080);
    check("mode80", mode, 7);
    points(5);
    check("mode85", mode, 7);
    pulse(1);
    pulse(2);
    check("pause_ret_state", state, 0);
    check("pause_ret_score", score, 16'h0000);
    check("pause_ret_mode", mode, 0);
    check("pause_ret_best", best, 16'h0008);

    pulse(0);
    points(9998);
    check("score9998", score, 16'h9998);
    points(3);
    check("score_sat", score, 16'h9999);
    check("mode_sat", mode, 7);
    do_hit();
    check("best9999", best, 16'h9999);
    pulse(2);
    pulse(0);
    points(30);
    check("score30", score, 16'h0030);

    @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    check("async_state", state, 0);
    check("async_clr",   clr,   1);
    check("async_tick",  tick,  0);
    check("async_score", score, 16'h0000);
    check("async_best",  best,  16'h0000);
    check("async_mode",  mode,  0);
    start = 1'b1;
    @(negedge clk);
    clr_n = 1'b1;
    cyc(6);
    check("held_start_idle", state, 0);
    start = 1'b0;
    cyc(2);
    pulse(0);
    check("restart_play", state, 1);
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
